// File: rtl/ibex_axil_bridge.sv
// Ibex data-port (req/gnt/rvalid) to AXI4-lite master bridge with an address
// window check and a response timeout; one transaction in flight at a time.
module ibex_axil_bridge #(
  parameter logic [31:0] ADDR_LO = 32'h4000,
  parameter logic [31:0] ADDR_HI = 32'h40DC,
  parameter int          TIMEOUT = 256,
  parameter int          DW      = 32,
  parameter int          AW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req,
  output logic          data_gnt,
  output logic          data_rvalid,
  input  logic          data_we,
  input  logic [3:0]    data_be,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_err,
  output logic [AW-1:0] awaddr,
  output logic          awvalid,
  input  logic          awready,
  output logic [DW-1:0] wdata,
  output logic [3:0]    wstrb,
  output logic          wvalid,
  input  logic          wready,
  input  logic          bvalid,
  output logic          bready,
  input  logic [1:0]    bresp,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic          rvalid,
  output logic          rready,
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, RESP, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_win;
  logic          expire;
  logic          aw_done;
  logic          w_done;
  logic          resp_unused;

  assign data_gnt    = data_req && (state == IDLE);
  assign in_win      = (data_addr >= AW'(ADDR_LO)) && (data_addr < AW'(ADDR_HI));
  // The counter is registered, so expiry is flagged one count early: the
  // state change lands exactly when the count reaches TIMEOUT-1.
  assign expire      = (cnt == CW'(TIMEOUT - 2));
  assign aw_done     = !awvalid || awready;
  assign w_done      = !wvalid || wready;
  assign resp_unused = bresp[0] ^ rresp[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      data_rvalid <= 1'b0;
      data_err    <= 1'b0;
      data_rdata  <= '0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            cnt <= '0;
            if (!in_win) begin
              state <= RESP;
            end else if (data_we) begin
              state   <= WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= data_addr;
              wdata   <= data_wdata;
              wstrb   <= data_be;
            end else begin
              state   <= RD;
              arvalid <= 1'b1;
              araddr  <= data_addr;
            end
          end
        end
        WR: begin
          cnt <= cnt + CW'(1);
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (expire) begin
            state       <= DRAIN;
            bready      <= 1'b1;
            data_rvalid <= 1'b1;
            data_err    <= 1'b1;
            data_rdata  <= '0;
          end else if (aw_done && w_done) begin
            state  <= WAIT_B;
            bready <= 1'b1;
          end
        end
        WAIT_B: begin
          cnt <= cnt + CW'(1);
          if (bvalid) begin
            state       <= RESP;
            bready      <= 1'b0;
            data_rvalid <= 1'b1;
            data_err    <= bresp[1];
            data_rdata  <= '0;
          end else if (expire) begin
            state       <= DRAIN;
            data_rvalid <= 1'b1;
            data_err    <= 1'b1;
            data_rdata  <= '0;
          end
        end
        RD: begin
          cnt <= cnt + CW'(1);
          if (arready) arvalid <= 1'b0;
          if (expire) begin
            state       <= DRAIN;
            rready      <= 1'b1;
            data_rvalid <= 1'b1;
            data_err    <= 1'b1;
            data_rdata  <= '0;
          end else if (arready) begin
            state  <= WAIT_R;
            rready <= 1'b1;
          end
        end
        WAIT_R: begin
          cnt <= cnt + CW'(1);
          if (rvalid) begin
            state       <= RESP;
            rready      <= 1'b0;
            data_rvalid <= 1'b1;
            data_err    <= rresp[1];
            data_rdata  <= rdata;
          end else if (expire) begin
            state       <= DRAIN;
            data_rvalid <= 1'b1;
            data_err    <= 1'b1;
            data_rdata  <= '0;
          end
        end
        // Decode errors arrive here without a pulse pending and spend one
        // extra cycle raising it; AXI completions arrive with it already set.
        RESP: begin
          if (data_rvalid) begin
            state       <= IDLE;
            data_rvalid <= 1'b0;
            data_err    <= 1'b0;
          end else begin
            data_rvalid <= 1'b1;
            data_err    <= 1'b1;
            data_rdata  <= '0;
          end
        end
        DRAIN: begin
          data_rvalid <= 1'b0;
          data_err    <= 1'b0;
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (arready) arvalid <= 1'b0;
          if ((bvalid && bready) || (rvalid && rready)) begin
            state  <= IDLE;
            bready <= 1'b0;
            rready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ibex_axil_bridge.sv
// Scoreboard bench for ibex_axil_bridge: a core-side driver, a randomised AXI
// slave, and a monitor that checks every data_rvalid against a response model.
module tb_ibex_axil_bridge;
  localparam logic [31:0] LO = 32'h4000;
  localparam logic [31:0] HI = 32'h40DC;
  localparam int TO = 16;
  localparam int LATE = 20;

  logic        clk_i, rst_ni;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  typedef struct {
    bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    logic [3:0] be; int aw_dly; int w_dly; int r_dly; logic [1:0] resp;
  } cfg_t;
  typedef struct {
    string name; logic [31:0] rdata; bit err; int gnt_cyc; int lat;
  } exp_t;

  cfg_t cfg_q[$];
  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   slave_busy = 0;

  ibex_axil_bridge #(.ADDR_LO(LO), .ADDR_HI(HI), .TIMEOUT(TO), .DW(32), .AW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req(data_req), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_err(data_err), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .araddr(araddr),
    .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp)
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: the response the core must see for one access.
  function automatic exp_t model(input string nm, input cfg_t c, input int lat);
    exp_t e;
    e.name = nm; e.lat = lat; e.gnt_cyc = 0;
    if (c.addr < LO || c.addr >= HI || c.r_dly >= LATE) begin
      e.err = 1; e.rdata = 32'h0;
    end else begin
      e.err = c.resp[1]; e.rdata = c.we ? 32'h0 : c.rdata;
    end
    return e;
  endfunction

  // ---------------- AXI slave ----------------
  task automatic do_write(input cfg_t c);
    int awc = c.aw_dly, wc = c.w_dly, n = 0;
    bit awd = 0, wd = 0, hs_aw, hs_w;
    while (!(awd && wd)) begin
      if (!rst_ni) begin awready = 0; wready = 0; return; end
      check("bready_early", bready, 0);
      hs_aw = 0; hs_w = 0;
      if (!awd) begin
        check("awvalid_hold", awvalid, 1);
        awready = (awc == 0); if (awc > 0) awc--;
        if (awready && awvalid) begin
          hs_aw = 1; check("awaddr", awaddr, c.addr);
        end
      end else check("awvalid_drop", awvalid, 0);
      if (!wd) begin
        check("wvalid_hold", wvalid, 1);
        wready = (wc == 0); if (wc > 0) wc--;
        if (wready && wvalid) begin
          hs_w = 1; check("wdata", wdata, c.wdata); check("wstrb", wstrb, c.be);
        end
      end else check("wvalid_drop", wvalid, 0);
      @(posedge clk_i); #1;
      awready = 0; wready = 0;
      awd |= hs_aw; wd |= hs_w;
      if (++n > 100) begin check("aw_w_handshake_timeout", 0, 1); return; end
    end
    if (rst_ni) check("bready_set", bready, 1);
    repeat (c.r_dly) begin
      @(posedge clk_i); #1;
      if (!rst_ni) return;
    end
    bvalid = 1; bresp = c.resp; n = 0;
    while (!bready) begin
      @(posedge clk_i); #1;
      if (!rst_ni || ++n > 100) begin
        if (rst_ni) check("bready_timeout", 0, 1);
        bvalid = 0; return;
      end
    end
    @(posedge clk_i); #1;
    bvalid = 0;
  endtask

  task automatic do_read(input cfg_t c);
    int arc = c.aw_dly, n = 0;
    bit hs = 0;
    while (!hs) begin
      if (!rst_ni) begin arready = 0; return; end
      check("arvalid_hold", arvalid, 1);
      check("rready_early", rready, 0);
      arready = (arc == 0); if (arc > 0) arc--;
      if (arready && arvalid) begin hs = 1; check("araddr", araddr, c.addr); end
      @(posedge clk_i); #1;
      arready = 0;
      if (++n > 100) begin check("ar_handshake_timeout", 0, 1); return; end
    end
    if (rst_ni) begin check("rready_set", rready, 1); check("arvalid_drop", arvalid, 0); end
    repeat (c.r_dly) begin
      @(posedge clk_i); #1;
      if (!rst_ni) return;
    end
    rvalid = 1; rresp = c.resp; rdata = c.rdata; n = 0;
    while (!rready) begin
      @(posedge clk_i); #1;
      if (!rst_ni || ++n > 100) begin
        if (rst_ni) check("rready_timeout", 0, 1);
        rvalid = 0; return;
      end
    end
    @(posedge clk_i); #1;
    rvalid = 0; rdata = $urandom;
  endtask

  initial begin : slave
    cfg_t c;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_ni && (awvalid || wvalid || arvalid)) begin
        if (cfg_q.size() == 0) begin
          check("axi_valid_unexpected", {awvalid, wvalid, arvalid}, 0);
        end else begin
          c = cfg_q.pop_front();
          slave_busy = 1;
          if (c.we) do_write(c); else do_read(c);
          slave_busy = 0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && data_rvalid) begin
        if (exp_q.size() == 0) begin
          check("data_rvalid_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, data_rdata, e.rdata);
          check({e.name, "_err"}, data_err, e.err);
          if (e.lat >= 0) check({e.name, "_latency"}, cyc - e.gnt_cyc, e.lat);
        end
      end
    end
  end

  // ---------------- core-side driver ----------------
  task automatic issue(input string nm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int ad,
                       input int wdly, input int rdly, input logic [1:0] resp,
                       input logic [31:0] rdv, input int lat);
    cfg_t c; exp_t e; int n = 0;
    c.we = we; c.addr = addr; c.wdata = wd; c.be = be; c.aw_dly = ad;
    c.w_dly = wdly; c.r_dly = rdly; c.resp = resp; c.rdata = rdv;
    e = model(nm, c, lat);
    if (addr >= LO && addr < HI) cfg_q.push_back(c);
    data_req = 1; data_we = we; data_addr = addr; data_wdata = wd; data_be = be;
    forever begin
      @(negedge clk_i);
      if (data_gnt) break;
      if (++n > 200) begin
        check({nm, "_gnt_timeout"}, 0, 1);
        data_req = 0; return;
      end
    end
    check({nm, "_gnt_while_slave_busy"}, slave_busy, 0);
    e.gnt_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    data_req = 0; data_we = $urandom; data_addr = $urandom;
    data_wdata = $urandom; data_be = $urandom;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (exp_q.size() != 0 || slave_busy) begin
      @(negedge clk_i);
      if (++n > 400) begin check("drain_timeout", exp_q.size(), 0); return; end
    end
  endtask

  initial begin : main
    logic [31:0] a;
    int sel, n;
    data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_awvalid", awvalid, 0);  check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);  check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);    check("rst_data_rvalid", data_rvalid, 0);
    check("rst_data_err", data_err, 0); check("rst_data_rdata", data_rdata, 0);
    check("rst_awaddr", awaddr, 0);    check("rst_araddr", araddr, 0);
    check("rst_wdata", wdata, 0);      check("rst_wstrb", wstrb, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    issue("wr_min", 1, 32'h4010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 3);
    issue("rd_ar_delay", 0, 32'h4000, 0, 4'hF, 2, 0, 0, 2'b00, 32'h12345678, -1);
    issue("wr_split_slverr", 1, 32'h4020, 32'hA5A55A5A, 4'h3, 3, 0, 0, 2'b10, 0, -1);
    issue("rd_below_window", 0, 32'h3000, 0, 4'hF, 0, 0, 0, 2'b00, 0, 2);
    issue("wr_at_window_end", 1, 32'h40DC, 32'h1, 4'hF, 0, 0, 0, 2'b00, 0, 2);
    issue("rd_decerr", 0, 32'h40D8, 0, 4'hF, 1, 0, 2, 2'b11, 32'hCAFEF00D, -1);
    issue("rd_timeout", 0, 32'h4004, 0, 4'hF, 0, 0, LATE, 2'b00, 32'h77, TO);
    issue("wr_after_drain", 1, 32'h4008, 32'h55, 4'h1, 0, 0, 0, 2'b00, 0, 3);
    wait_quiet();

    issue("wr_reset", 1, 32'h400C, 32'h99, 4'hF, 0, 0, 8, 2'b00, 0, -1);
    n = 0;
    while (!bready && n < 50) begin @(negedge clk_i); n++; end
    check("reset_reached_wait_b", bready, 1);
    @(negedge clk_i);
    rst_ni = 0;
    #1;
    exp_q.delete(); cfg_q.delete();
    check("mid_rst_awvalid", awvalid, 0); check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_arvalid", arvalid, 0); check("mid_rst_bready", bready, 0);
    check("mid_rst_rready", rready, 0);   check("mid_rst_data_rvalid", data_rvalid, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i); #1;
    issue("rd_after_reset", 0, 32'h4030, 0, 4'hF, 0, 0, 0, 2'b01, 32'h0BADCAFE, 3);
    wait_quiet();

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) a = LO + ($urandom_range(0, 54) << 2);
      else if (sel < 8) a = ($urandom_range(0, 1) == 1) ? HI + ($urandom_range(0, 15) << 2)
                                                       : LO - 4 - ($urandom_range(0, 15) << 2);
      else a = $urandom;
      issue("rnd", $urandom_range(0, 1), a, $urandom, 4'($urandom_range(1, 15)),
            $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? LATE + $urandom_range(0, 4) : $urandom_range(0, 3),
            2'($urandom_range(0, 3)), $urandom, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    wait_quiet();
    repeat (5) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
